// File: rtl/autoencoder_pkg.sv
// autoencoder_pkg: shared lane geometry and serializer state encoding.
// Revision 1.0
`default_nettype none

package autoencoder_pkg;

  localparam int DATA_W  = 16;
  localparam int N_LANES = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage : autoencoder_pkg

`default_nettype wire

// File: rtl/mux_4_1.sv
// mux_4_1: combinational 4-to-1 lane selector, DATA_W bits per lane.
// Revision 1.0
`default_nettype none

module mux_4_1 #(
  parameter int DATA_W = autoencoder_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] lane0_i,
  input  logic [DATA_W-1:0] lane1_i,
  input  logic [DATA_W-1:0] lane2_i,
  input  logic [DATA_W-1:0] lane3_i,
  input  logic [1:0]        sel_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = lane0_i;
    case (sel_i)
      2'd0:    data_o = lane0_i;
      2'd1:    data_o = lane1_i;
      2'd2:    data_o = lane2_i;
      2'd3:    data_o = lane3_i;
      default: data_o = lane0_i;
    endcase
  end

endmodule : mux_4_1

`default_nettype wire

// File: rtl/mux_4_1_serializer.sv
// mux_4_1_serializer: captures a 4-lane frame and emits it one word per accepted beat.
// Revision 1.0 -- optional out_last port enabled by defining MUX41_LAST_FLAG_EN.
`default_nettype none

module mux_4_1_serializer #(
  parameter int DATA_W  = autoencoder_pkg::DATA_W,
  parameter int N_LANES = autoencoder_pkg::N_LANES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic [DATA_W-1:0] in_4,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef MUX41_LAST_FLAG_EN
  output logic              out_last,
`endif
  output logic              busy
);

  import autoencoder_pkg::*;

  // Only N_LANES == 4 is supported; the select width follows from it.
  localparam int               SEL_W    = $clog2(N_LANES);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_LANES - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] lane_q [N_LANES];
  logic [DATA_W-1:0] lane_d [N_LANES];
  logic [DATA_W-1:0] mux_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      for (int i = 0; i < N_LANES; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      for (int i = 0; i < N_LANES; i++) begin
        lane_q[i] <= lane_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    for (int i = 0; i < N_LANES; i++) begin
      lane_d[i] = lane_q[i];
    end
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          lane_d[0] = in_1;
          lane_d[1] = in_2;
          lane_d[2] = in_3;
          lane_d[3] = in_4;
          sel_d     = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        // in_valid is deliberately not looked at here: held words stay frozen.
        if (out_ready) begin
          if (sel_q == LAST_SEL) begin
            sel_d   = '0;
            state_d = ST_IDLE;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  mux_4_1 #(
    .DATA_W (DATA_W)
  ) u_mux (
    .lane0_i (lane_q[0]),
    .lane1_i (lane_q[1]),
    .lane2_i (lane_q[2]),
    .lane3_i (lane_q[3]),
    .sel_i   (sel_q),
    .data_o  (mux_data)
  );

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_SEND);
    busy      = (state_q == ST_SEND);
    out_sel   = sel_q;
    out_data  = mux_data;
  end

`ifdef MUX41_LAST_FLAG_EN
  assign out_last = out_valid && (sel_q == LAST_SEL);
`endif

endmodule : mux_4_1_serializer

`default_nettype wire

// File: tb/tb_mux_4_1_serializer.sv
// tb_mux_4_1_serializer: directed self-checking bench for mux_4_1_serializer.
// Revision 1.0
`default_nettype none

module tb_mux_4_1_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_1, in_2, in_3, in_4;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef MUX41_LAST_FLAG_EN
  logic        out_last;
`endif

  int checks;
  int errors;

  mux_4_1_serializer #(
    .DATA_W  (16),
    .N_LANES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_1      (in_1),
    .in_2      (in_2),
    .in_3      (in_3),
    .in_4      (in_4),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MUX41_LAST_FLAG_EN
    .out_last  (out_last),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    in_1 = a; in_2 = b; in_3 = c; in_4 = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    set_lanes(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", out_data); end
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", out_sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    logic [15:0] exp_w [4];
    exp_w[0] = 16'h0001; exp_w[1] = 16'h0002; exp_w[2] = 16'h0003; exp_w[3] = 16'h0004;
    set_lanes(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid beat %0d got %b exp 1", k, out_valid); end
      checks++; if (out_data !== exp_w[k]) begin errors++; $display("FAIL basic_data beat %0d got %h exp %h", k, out_data, exp_w[k]); end
      checks++; if (out_sel !== 2'(k)) begin errors++; $display("FAIL basic_sel beat %0d got %0d exp %0d", k, out_sel, k); end
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_flags beat %0d got in_ready %b busy %b exp 0 1", k, in_ready, busy); end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_end got valid %b in_ready %b busy %b exp 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    set_lanes(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL bp_first got %h exp 0001", out_data); end
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_data !== 16'h0002 || out_sel !== 2'd1 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold cyc %0d got data %h sel %0d valid %b exp 0002 1 1", k, out_data, out_sel, out_valid);
      end
      tick();
    end
    out_ready = 1'b1;
    checks++; if (out_data !== 16'h0002 || out_sel !== 2'd1) begin errors++; $display("FAIL bp_release got %h sel %0d exp 0002 1", out_data, out_sel); end
    tick();
    checks++; if (out_data !== 16'h0003 || out_sel !== 2'd2) begin errors++; $display("FAIL bp_third got %h sel %0d exp 0003 2", out_data, out_sel); end
    tick();
    checks++; if (out_data !== 16'h0004 || out_sel !== 2'd3) begin errors++; $display("FAIL bp_fourth got %h sel %0d exp 0004 3", out_data, out_sel); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_ignored_input();
    logic [15:0] exp_w [4];
    exp_w[0] = 16'h0005; exp_w[1] = 16'h0006; exp_w[2] = 16'h0007; exp_w[3] = 16'h0008;
    set_lanes(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    set_lanes(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_data !== exp_w[k] || out_sel !== 2'(k)) begin
        errors++; $display("FAIL ign_data beat %0d got %h sel %0d exp %h %0d", k, out_data, out_sel, exp_w[k], k);
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ign_in_ready beat %0d got %b exp 0", k, in_ready); end
      tick();
    end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ign_idle got in_ready %b valid %b exp 1 0", in_ready, out_valid); end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_data !== 16'hAAAA || out_sel !== 2'(k)) begin
        errors++; $display("FAIL ign_new beat %0d got %h sel %0d exp aaaa %0d", k, out_data, out_sel, k);
      end
      tick();
    end
  endtask

  task automatic test_midframe_reset();
    set_lanes(16'h0009, 16'h000A, 16'h000B, 16'h000C);
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (out_data !== 16'h000B || out_sel !== 2'd2) begin errors++; $display("FAIL mr_pre got %h sel %0d exp 000b 2", out_data, out_sel); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || busy !== 1'b0) begin
      errors++; $display("FAIL mr_async got valid %b data %h busy %b exp 0 0000 0", out_valid, out_data, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mr_release got in_ready %b valid %b exp 1 0", in_ready, out_valid); end
    set_lanes(16'h0021, 16'h0022, 16'h0023, 16'h0024);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_sel !== 2'd0 || out_data !== 16'h0021) begin errors++; $display("FAIL mr_restart got %h sel %0d exp 0021 0", out_data, out_sel); end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_sign_width();
    logic [15:0] exp_w [4];
    exp_w[0] = 16'h8000; exp_w[1] = 16'hFFFF; exp_w[2] = 16'h7FFF; exp_w[3] = 16'h0000;
    set_lanes(16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000);
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_data !== exp_w[k] || out_sel !== 2'(k)) begin
        errors++; $display("FAIL sign_data beat %0d got %h sel %0d exp %h %0d", k, out_data, out_sel, exp_w[k], k);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_a [4];
    logic [15:0] exp_b [4];
    logic        exp_v;
    logic [15:0] exp_d;
    exp_a[0] = 16'h0101; exp_a[1] = 16'h0202; exp_a[2] = 16'h0303; exp_a[3] = 16'h0404;
    exp_b[0] = 16'hB001; exp_b[1] = 16'hB002; exp_b[2] = 16'hB003; exp_b[3] = 16'hB004;
    set_lanes(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) set_lanes(16'hB001, 16'hB002, 16'hB003, 16'hB004);
      if (c == 6) in_valid = 1'b0;
      exp_v = (c != 0) && (c != 5);
      exp_d = (c >= 1 && c <= 4) ? exp_a[c-1] : (c >= 6) ? exp_b[c-6] : out_data;
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_valid cyc %0d got %b exp %b", c, out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL b2b_data cyc %0d got %h exp %h", c, out_data, exp_d); end
      end
`ifdef MUX41_LAST_FLAG_EN
      checks++; if (out_last !== ((c == 4) || (c == 9))) begin
        errors++; $display("FAIL b2b_last cyc %0d got %b exp %b", c, out_last, (c == 4) || (c == 9));
      end
`endif
      tick();
    end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got busy %b valid %b exp 0 0", busy, out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_input();
    test_midframe_reset();
    test_sign_width();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_4_1_serializer

`default_nettype wire

// File: doc/mux_4_1_serializer.md
MUX_4_1_SERIALIZER -- requirements
Module: mux_4_1_serializer

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of every data lane (signed fixed-point word).
REQ-002 Parameter N_LANES, default 4, SHALL set the lane count; only the value 4 is supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark in_1..in_4 as carrying one frame.
REQ-006 in_ready  output  1  SHALL indicate that a frame can be captured this cycle.
REQ-007 in_1, in_2, in_3, in_4  input  DATA_W each  SHALL be the four parallel lane words.
REQ-008 out_data  output  DATA_W  SHALL be the serialized word.
REQ-009 out_sel  output  2  SHALL be the source lane index of out_data (0 = in_1 .. 3 = in_4).
REQ-010 out_valid  output  1  SHALL qualify out_data and out_sel.
REQ-011 out_ready  input  1  SHALL be the downstream acceptance signal.
REQ-012 busy  output  1  SHALL be high whenever a captured frame is not fully sent.

Function
REQ-013 FSM SHALL have two states: IDLE and SEND.
REQ-014 IDLE: in_ready=1 and out_valid=0; when in_valid=1, the block SHALL register all four lanes, set sel=0, and enter SEND on the next edge.
REQ-015 SEND: in_ready=0 and out_valid=1; out_data SHALL equal the held word for sel and out_sel SHALL equal sel.
REQ-016 A beat SHALL transfer only on out_valid && out_ready; on transfer, sel SHALL increment by 1 when sel<3, and SHALL return to IDLE with sel=0 when sel==3.
REQ-017 While out_ready=0 in SEND, out_data, out_sel and out_valid SHALL stay unchanged (no-drop, no-duplicate).
REQ-018 in_valid while in SEND SHALL be ignored; the held words SHALL NOT change until the next capture.
REQ-019 Latency: the first word SHALL be valid the cycle after capture; one frame SHALL take at least 5 cycles (1 IDLE + 4 SEND).
REQ-020 Words SHALL pass bit-exact: no arithmetic, truncation or sign change.
REQ-021 busy SHALL equal (state == SEND).

Reset
REQ-022 While rst_n=0, the block SHALL be in IDLE with sel=0, held words=0, out_data=0, out_sel=0, out_valid=0, busy=0 and in_ready=1 after release.
REQ-023 Reset asserted in SEND SHALL drop the partial frame immediately, without completing the remaining beats.

Configuration
REQ-024 With MUX41_LAST_FLAG_EN defined, a 1-bit output out_last SHALL be present, equal to out_valid && (sel==3).
REQ-025 Without MUX41_LAST_FLAG_EN, out_last SHALL NOT exist and all other behaviour SHALL be identical.

Structure
REQ-026 DATA_W, N_LANES and the IDLE/SEND state encoding SHALL live in the shared package autoencoder_pkg.
REQ-027 Lane selection SHALL use a combinational sub-module mux_4_1 (4 x DATA_W in, 2-bit select, DATA_W out). The sequencing logic SHALL stay in mux_4_1_serializer.

Verification
REQ-028 Basic frame: in_1..4=0x0001,0x0002,0x0003,0x0004, in_valid for 1 cycle, out_ready=1 -> out_data 1,2,3,4 with out_sel 0..3 on four consecutive cycles, then IDLE.
REQ-029 Backpressure: out_ready=0 for 3 cycles at sel=1 -> out_data stays 0x0002 and out_sel stays 1; after release, 0x0003 and 0x0004 follow with no loss.
REQ-030 Ignored input: in_valid=1 with new values 0xAAAA during SEND -> current frame output unchanged and in_ready=0; the new values are captured only in the next IDLE cycle.
REQ-031 Mid-frame reset: rst_n low at sel=2 -> out_valid=0 and out_data=0 immediately; after release in_ready=1, and the next frame starts at out_sel=0.
REQ-032 Sign/width: lanes 0x8000, 0xFFFF, 0x7FFF, 0x0000 -> emitted bit-exact in order.
REQ-033 Back-to-back with MUX41_LAST_FLAG_EN: two frames with in_valid held high -> out_last high only on each 4th beat; 10 cycles total with out_ready=1.
